// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the multi-lane writeback stage
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int REG_ZERO = 0;
  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } load_size_t;
  typedef struct packed {
    logic                 valid;
    logic                 write_en;
    logic                 is_load;
    load_size_t           size;
    logic                 uns;
    logic [1:0]           addr_low;
    logic [WB_DATA_W-1:0] result;
    logic [WB_DATA_W-1:0] mem_rdata;
  } wb_lane_t;
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a load word and extends it
module load_align
  import wb_pkg::*;
(
  input  logic [WB_DATA_W-1:0] mem_rdata_i,
  input  logic [1:0]           addr_low_i,
  input  load_size_t           size_i,
  input  logic                 unsigned_i,
  output logic [WB_DATA_W-1:0] data_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  always_comb begin
    byte_v = 8'(mem_rdata_i >> {addr_low_i, 3'b000});
    half_v = addr_low_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    data_o = size_i == LS_BYTE ? {{24{~unsigned_i & byte_v[7]}}, byte_v} :
             size_i == LS_HALF ? {{16{~unsigned_i & half_v[15]}}, half_v} :
             mem_rdata_i;
  end
endmodule

// File: rtl/wb_stage_multi.sv
// wb_stage_multi: registered multi-lane writeback with load alignment and youngest-wins write arbitration
module wb_stage_multi
  import wb_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [LANES-1:0]            in_valid,
  input  logic [LANES*DATA_W-1:0]     in_result,
  input  logic [LANES*REG_ADDR_W-1:0] in_reg_dest,
  input  logic [LANES-1:0]            in_write_en,
  input  logic [LANES-1:0]            in_is_load,
  input  logic [LANES*2-1:0]          in_load_size,
  input  logic [LANES-1:0]            in_load_unsigned,
  input  logic [LANES*2-1:0]          in_addr_low,
  input  logic [LANES*DATA_W-1:0]     in_mem_rdata,
  output logic [LANES-1:0]            reg_write_en,
  output logic [LANES*REG_ADDR_W-1:0] reg_write_dest,
  output logic [LANES*DATA_W-1:0]     reg_write_data,
  output logic [LANES-1:0]            fwd_valid,
  output logic [CNT_W-1:0]            retired_count
);
  wb_lane_t              lane_d [LANES];
  wb_lane_t              lane_q [LANES];
  logic [REG_ADDR_W-1:0] dest_d [LANES];
  logic [REG_ADDR_W-1:0] dest_q [LANES];
  logic [DATA_W-1:0]     aligned [LANES];
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic [LANES-1:0]      en;
  logic                  take;
  always_comb begin
    take  = ~stall & ~flush;
    cnt_d = cnt_q;
    for (int l = 0; l < LANES; l++) begin
      lane_d[l].valid     = take & in_valid[l];
      lane_d[l].write_en  = in_write_en[l];
      lane_d[l].is_load   = in_is_load[l];
      lane_d[l].size      = in_load_size[2*l +: 2] == 2'd3 ? LS_WORD : load_size_t'(in_load_size[2*l +: 2]);
      lane_d[l].uns       = in_load_unsigned[l];
      lane_d[l].addr_low  = in_addr_low[2*l +: 2];
      lane_d[l].result    = in_result[DATA_W*l +: DATA_W];
      lane_d[l].mem_rdata = in_mem_rdata[DATA_W*l +: DATA_W];
      dest_d[l]           = in_reg_dest[REG_ADDR_W*l +: REG_ADDR_W];
      cnt_d               = cnt_d + CNT_W'(lane_q[l].valid);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        lane_q[l] <= '0;
        dest_q[l] <= '0;
      end
      cnt_q <= '0;
    end else begin
      lane_q <= lane_d;
      dest_q <= dest_d;
      cnt_q  <= cnt_d;
    end
  end
  // Older lane loses to any younger lane writing the same register.
  always_comb begin
    for (int l = 0; l < LANES; l++)
      en[l] = lane_q[l].valid & lane_q[l].write_en & (dest_q[l] != REG_ADDR_W'(REG_ZERO));
    for (int l = 0; l < LANES; l++)
      for (int k = l + 1; k < LANES; k++)
        if (en[k] && dest_q[k] == dest_q[l]) en[l] = 1'b0;
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    load_align u_align (
      .mem_rdata_i (lane_q[i].mem_rdata),
      .addr_low_i  (lane_q[i].addr_low),
      .size_i      (lane_q[i].size),
      .unsigned_i  (lane_q[i].uns),
      .data_o      (aligned[i])
    );
    assign reg_write_dest[REG_ADDR_W*i +: REG_ADDR_W] = dest_q[i];
    assign reg_write_data[DATA_W*i +: DATA_W] = lane_q[i].is_load ? aligned[i] : lane_q[i].result;
  end
  assign reg_write_en  = en;
  assign fwd_valid     = en;
  assign retired_count = cnt_q;
endmodule

// File: tb/tb_wb_stage_multi.sv
// tb_wb_stage_multi: directed and random checks of wb_stage_multi against a behavioural model
module tb_wb_stage_multi;
  logic        clk = 1'b0, rst = 1'b1, stall, flush;
  logic [1:0]  in_valid, in_write_en, in_is_load, in_load_unsigned;
  logic [63:0] in_result, in_mem_rdata;
  logic [9:0]  in_reg_dest;
  logic [3:0]  in_load_size, in_addr_low;
  logic [1:0]  reg_write_en, fwd_valid, reg_write_en4, fwd_valid4;
  logic [9:0]  reg_write_dest, reg_write_dest4;
  logic [63:0] reg_write_data, reg_write_data4;
  logic [31:0] retired_count;
  logic [3:0]  retired_count4;
  int n_checks = 0, n_fail = 0;
  bit chk_on = 0;
  logic [1:0]  m_v, m_en;
  logic [4:0]  m_dest [2];
  logic [31:0] m_data [2];
  logic [31:0] m_cnt;

  wb_stage_multi dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_result(in_result), .in_reg_dest(in_reg_dest), .in_write_en(in_write_en),
    .in_is_load(in_is_load), .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_addr_low(in_addr_low), .in_mem_rdata(in_mem_rdata), .reg_write_en(reg_write_en),
    .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data), .fwd_valid(fwd_valid),
    .retired_count(retired_count));
  wb_stage_multi #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_result(in_result), .in_reg_dest(in_reg_dest), .in_write_en(in_write_en),
    .in_is_load(in_is_load), .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_addr_low(in_addr_low), .in_mem_rdata(in_mem_rdata), .reg_write_en(reg_write_en4),
    .reg_write_dest(reg_write_dest4), .reg_write_data(reg_write_data4), .fwd_valid(fwd_valid4),
    .retired_count(retired_count4));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] rd, input logic [1:0] al,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * al)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = al[1] ? rd >> 16 : rd & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  task automatic model_clear();
    m_v = 0; m_en = 0; m_cnt = 0;
    for (int l = 0; l < 2; l++) begin m_dest[l] = 0; m_data[l] = 0; end
  endtask

  task automatic model_update();
    int owner [32];
    if (rst) begin model_clear(); return; end
    m_cnt = m_cnt + 32'($countones(m_v));
    for (int r = 0; r < 32; r++) owner[r] = -1;
    for (int l = 0; l < 2; l++) begin
      m_v[l]    = !stall && !flush && in_valid[l];
      m_dest[l] = in_reg_dest[l*5 +: 5];
      m_data[l] = in_is_load[l] ? load_val(in_mem_rdata[l*32 +: 32], in_addr_low[l*2 +: 2],
                                           in_load_size[l*2 +: 2], in_load_unsigned[l])
                                : in_result[l*32 +: 32];
      if (m_v[l] && in_write_en[l] && m_dest[l] != 0) owner[m_dest[l]] = l;
    end
    for (int l = 0; l < 2; l++)
      m_en[l] = m_v[l] && in_write_en[l] && m_dest[l] != 0 && owner[m_dest[l]] == l;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; in_valid = 0; in_write_en = 0; in_is_load = 0; in_load_unsigned = 0;
    in_result = 0; in_mem_rdata = 0; in_reg_dest = 0; in_load_size = 0; in_addr_low = 0;
  endtask

  task automatic set_lane(input int l, input logic [4:0] d, input logic [31:0] res, input logic ld,
                          input logic [1:0] sz, input logic uns, input logic [1:0] al,
                          input logic [31:0] rd);
    in_valid[l] = 1; in_write_en[l] = 1; in_reg_dest[l*5 +: 5] = d; in_result[l*32 +: 32] = res;
    in_is_load[l] = ld; in_load_size[l*2 +: 2] = sz; in_load_unsigned[l] = uns;
    in_addr_low[l*2 +: 2] = al; in_mem_rdata[l*32 +: 32] = rd;
  endtask

  task automatic async_reset();
    #2 rst = 1;
    model_clear();
    #1;
    check("rst_en", 64'(reg_write_en), 64'h0);
    check("rst_cnt", 64'(retired_count), 64'h0);
    check("rst_cnt4", 64'(retired_count4), 64'h0);
    idle();
    @(posedge clk);
    model_update();
    #3 rst = 0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("en", 64'(reg_write_en), 64'(m_en));
      check("fwd", 64'(fwd_valid), 64'(m_en));
      check("cnt", 64'(retired_count), 64'(m_cnt));
      check("cnt4", 64'(retired_count4), 64'(m_cnt[3:0]));
      for (int l = 0; l < 2; l++)
        if (m_en[l]) begin
          check("dest", 64'(reg_write_dest[l*5 +: 5]), 64'(m_dest[l]));
          check("data", 64'(reg_write_data[l*32 +: 32]), 64'(m_data[l]));
        end
    end
  end

  initial begin
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_en", 64'(reg_write_en), 64'h0);
    check("reset_dest", 64'(reg_write_dest), 64'h0);
    check("reset_data", reg_write_data, 64'h0);
    check("reset_cnt", 64'(retired_count), 64'h0);
    rst = 0;
    chk_on = 1;
    set_lane(0, 5'd3, 32'h1234_5678, 0, 2'd0, 0, 2'd0, 32'h0);
    tick();
    check("alu_en", 64'(reg_write_en), 64'h1);
    check("alu_dest", 64'(reg_write_dest[4:0]), 64'd3);
    check("alu_data", 64'(reg_write_data[31:0]), 64'h1234_5678);
    idle();
    tick();
    check("alu_cnt", 64'(retired_count), 64'd1);
    set_lane(0, 5'd4, 32'h0, 1, 2'd0, 0, 2'd3, 32'h80FF_7F01);
    set_lane(1, 5'd5, 32'h0, 1, 2'd1, 1, 2'd2, 32'h80FF_7F01);
    tick();
    check("ld_en", 64'(reg_write_en), 64'h3);
    check("ld_sbyte3", 64'(reg_write_data[31:0]), 64'hFFFF_FF80);
    check("ld_uhalf2", 64'(reg_write_data[63:32]), 64'h0000_80FF);
    idle();
    set_lane(0, 5'd4, 32'h0, 1, 2'd0, 0, 2'd1, 32'h80FF_7F01);
    tick();
    check("ld_sbyte1", 64'(reg_write_data[31:0]), 64'h0000_007F);
    idle();
    set_lane(0, 5'd7, 32'hA, 0, 2'd0, 0, 2'd0, 32'h0);
    set_lane(1, 5'd7, 32'hB, 0, 2'd0, 0, 2'd0, 32'h0);
    tick();
    check("waw_en", 64'(reg_write_en), 64'h2);
    check("waw_data1", 64'(reg_write_data[63:32]), 64'hB);
    idle();
    set_lane(0, 5'd7, 32'hA, 0, 2'd0, 0, 2'd0, 32'h0);
    set_lane(1, 5'd0, 32'hB, 0, 2'd0, 0, 2'd0, 32'h0);
    tick();
    check("r0_en", 64'(reg_write_en), 64'h1);
    idle();
    tick();
    tick();
    for (int m = 0; m < 3; m++) begin
      set_lane(0, 5'd9, 32'h55, 0, 2'd0, 0, 2'd0, 32'h0);
      stall = (m != 1);
      flush = (m != 0);
      tick();
      check("sf_en", 64'(reg_write_en), 64'h0);
      idle();
      tick();
      check("sf_cnt", 64'(retired_count), 64'd8);
    end
    set_lane(0, 5'd9, 32'h66, 0, 2'd0, 0, 2'd0, 32'h0);
    tick();
    check("one_en", 64'(reg_write_en), 64'h1);
    stall = 1;
    tick();
    check("one_stall_en", 64'(reg_write_en), 64'h0);
    idle();
    tick();
    check("one_cnt", 64'(retired_count), 64'd9);
    async_reset();
    for (int k = 1; k <= 9; k++) begin
      idle();
      if (k <= 8) in_valid = 2'b11;
      tick();
      if (k >= 2) begin
        check("wrap4", 64'(retired_count4), 64'((2 * (k - 1)) % 16));
        check("wrap32", 64'(retired_count), 64'(2 * (k - 1)));
      end
    end
    idle();
    set_lane(0, 5'd6, 32'h77, 0, 2'd0, 0, 2'd0, 32'h0);
    tick();
    check("pend_en", 64'(reg_write_en), 64'h1);
    async_reset();
    tick();
    check("post_rst_en", 64'(reg_write_en), 64'h0);
    check("post_rst_cnt", 64'(retired_count), 64'h0);
    repeat (400) begin
      in_valid = 2'($urandom); in_write_en = 2'($urandom); in_is_load = 2'($urandom);
      in_load_unsigned = 2'($urandom); in_load_size = 4'($urandom); in_addr_low = 4'($urandom);
      in_reg_dest = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      in_result = {$urandom, $urandom}; in_mem_rdata = {$urandom, $urandom};
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      tick();
    end
    idle();
    tick();
    @(negedge clk);
    #1 chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
